// File: rtl/rvfi_commit_sequencer.sv
// Serializes a multi-port RVFI commit bundle into one in-order record stream.
// Define RVFI_SEQ_TOHOST_EN to build the tohost detector and drain-then-exit FSM.

package riscv;
  localparam int unsigned XLEN = 64;
endpackage

package rvfi_pkg;
  typedef struct packed {
    logic                   valid;
    logic [31:0]            insn;
    logic                   trap;
    logic [riscv::XLEN-1:0] pc_rdata;
    logic [riscv::XLEN-1:0] mem_addr;
    logic [7:0]             mem_wmask;
    logic [63:0]            mem_wdata;
  } rvfi_instr_t;
endpackage

// state | meaning
// RUN   | normal enqueue/dequeue
// DRAIN | tohost seen, enqueue off, popping until empty
// DONE  | terminal, exit_valid_o asserted until reset
module rvfi_commit_sequencer #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0]  rvfi_i,
  output logic                                         stall_o,
  output logic                                         rec_valid_o,
  output rvfi_pkg::rvfi_instr_t                        rec_o,
  input  logic                                         rec_ready_i,
  output logic [63:0]                                  seq_o,
  output logic [$clog2(DEPTH+1)-1:0]                   count_o,
  output logic                                         overflow_o,
  input  logic [riscv::XLEN-1:0]                       tohost_addr_i,
  output logic                                         exit_valid_o,
  output logic [63:0]                                  exit_code_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  rvfi_pkg::rvfi_instr_t mem_q [DEPTH];
  rvfi_pkg::rvfi_instr_t mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, free, n_push;
  logic [63:0]   seq_q, seq_d;
  logic          overflow_q, overflow_d;
  logic          pop, enq_en, cut;

`ifdef RVFI_SEQ_TOHOST_EN
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_e;
  state_e      state_q, state_d;
  logic [63:0] exit_code_q, exit_code_d;

  function automatic logic is_tohost(input rvfi_pkg::rvfi_instr_t r);
    return r.valid && (r.mem_wmask != '0) && (tohost_addr_i != '0) &&
           (r.mem_addr == tohost_addr_i) && r.mem_wdata[0] &&
           (r.mem_wdata[63:48] == 16'h0);
  endfunction
`endif

  assign free        = CW'(DEPTH) - count_q;
  assign rec_valid_o = (count_q != '0);
  assign rec_o       = rec_valid_o ? mem_q[rd_ptr_q] : '0;
  assign stall_o     = free < CW'(NR_COMMIT_PORTS);
  assign pop         = rec_valid_o && rec_ready_i;
  assign count_o     = count_q;
  assign seq_o       = seq_q;
  assign overflow_o  = overflow_q;

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    n_push     = '0;
    cut        = 1'b0;
`ifdef RVFI_SEQ_TOHOST_EN
    state_d     = state_q;
    exit_code_d = exit_code_q;
    enq_en      = (state_q == RUN);
`else
    enq_en      = 1'b1;
`endif
    // Compact eligible ports in ascending order into the free slots at cycle start.
    for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
      if (enq_en && !cut && (rvfi_i[p].valid || rvfi_i[p].trap)) begin
        if (n_push < free) begin
          mem_d[wr_ptr_q + PW'(n_push)] = rvfi_i[p];
          n_push = n_push + CW'(1);
`ifdef RVFI_SEQ_TOHOST_EN
          if (is_tohost(rvfi_i[p])) begin
            cut         = 1'b1;
            state_d     = DRAIN;
            exit_code_d = rvfi_i[p].mem_wdata;
          end
`endif
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
    if (flush_i) begin
      mem_d      = mem_q;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = overflow_q;
`ifdef RVFI_SEQ_TOHOST_EN
      state_d     = state_q;
      exit_code_d = exit_code_q;
`endif
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        seq_d    = seq_q + 64'd1;
      end
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      count_d  = count_q + n_push - CW'(pop);
    end
`ifdef RVFI_SEQ_TOHOST_EN
    if (state_q == DRAIN && count_d == '0) state_d = DONE;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef RVFI_SEQ_TOHOST_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      exit_code_q <= exit_code_d;
    end
  end

  assign exit_valid_o = (state_q == DONE);
  assign exit_code_o  = exit_valid_o ? exit_code_q : '0;
`else
  logic unused_tohost;
  assign unused_tohost = ^tohost_addr_i;
  assign exit_valid_o  = 1'b0;
  assign exit_code_o   = '0;
`endif

endmodule
